// File: rtl/interval_result_streamer.sv
// Snapshots the interval min/max engine's results on a rising done and streams
// them out one interval per valid/ready beat, flagging results that arrive while busy.
module interval_result_streamer #(
  parameter int NUM_INTERVALS = 10,
  parameter int DATA_W        = 32,
  parameter int IDX_W         = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            res_done,
  input  logic [NUM_INTERVALS*DATA_W-1:0] res_max,
  input  logic [NUM_INTERVALS*DATA_W-1:0] res_min,
  input  logic [IDX_W-1:0]                num_valid,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [IDX_W-1:0]                out_index,
  output logic [DATA_W-1:0]               out_min,
  output logic [DATA_W-1:0]               out_max,
  output logic                            out_last,
  output logic                            busy,
  output logic                            frame_done,
  output logic                            overrun
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_FIN    = 2'd2
  } state_t;

  localparam int              SEL_W     = (NUM_INTERVALS > 1) ? $clog2(NUM_INTERVALS) : 1;
  localparam logic [IDX_W-1:0] MAX_COUNT = IDX_W'(NUM_INTERVALS);

  state_t               state_q, state_d;
  logic                 done_q;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     count_q, count_d;
  logic                 overrun_q, overrun_d;
  logic [DATA_W-1:0]    snap_min_q [NUM_INTERVALS];
  logic [DATA_W-1:0]    snap_max_q [NUM_INTERVALS];

  logic                 rise;
  logic                 capture;
  logic                 beat_last;
  logic [IDX_W-1:0]     clamped_count;
  logic [SEL_W-1:0]     sel;

  assign rise          = res_done & ~done_q;
  assign clamped_count = (num_valid > MAX_COUNT) ? MAX_COUNT : num_valid;
  assign beat_last     = (idx_q == count_q - IDX_W'(1));
  // idx_q never reaches NUM_INTERVALS while streaming, so the low bits select the slot.
  assign sel           = idx_q[SEL_W-1:0];

  always_comb begin
    // NOTE: every next-state signal gets its default first so no latch can be inferred.
    state_d   = state_q;
    idx_d     = idx_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    capture   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (rise) begin
          capture = 1'b1;
          count_d = clamped_count;
          idx_d   = '0;
          state_d = (clamped_count == '0) ? S_FIN : S_STREAM;
        end
      end
      S_STREAM: begin
        if (rise) overrun_d = 1'b1;
        if (out_ready) begin
          if (beat_last) state_d = S_FIN;
          else           idx_d   = idx_q + IDX_W'(1);
        end
      end
      S_FIN: begin
        if (rise) overrun_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values together.
    if (reset) begin
      state_q   <= S_IDLE;
      done_q    <= 1'b1;  // a done already high at reset release must not look like a rise
      idx_q     <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      done_q    <= res_done;
      idx_q     <= idx_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the snapshot is plain flip-flops, not a RAM, so it can be cleared on reset.
    if (reset) begin
      for (int i = 0; i < NUM_INTERVALS; i++) begin
        snap_min_q[i] <= '0;
        snap_max_q[i] <= '0;
      end
    end else if (capture) begin
      for (int i = 0; i < NUM_INTERVALS; i++) begin
        snap_min_q[i] <= res_min[DATA_W*i +: DATA_W];
        snap_max_q[i] <= res_max[DATA_W*i +: DATA_W];
      end
    end
  end

  assign out_valid  = (state_q == S_STREAM);
  assign out_last   = out_valid & beat_last;
  assign out_index  = out_valid ? idx_q : '0;
  assign out_min    = out_valid ? snap_min_q[sel] : '0;
  assign out_max    = out_valid ? snap_max_q[sel] : '0;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = (state_q == S_FIN);
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_interval_result_streamer.sv
// Randomized bench for interval_result_streamer: a queue-of-beats reference model
// is compared against the DUT every cycle, plus literal checks on directed frames.
module tb_interval_result_streamer;
  localparam int N  = 10;
  localparam int DW = 32;
  localparam int IW = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            res_done;
  logic [N*DW-1:0] res_max;
  logic [N*DW-1:0] res_min;
  logic [IW-1:0]   num_valid;
  logic            out_valid;
  logic            out_ready;
  logic [IW-1:0]   out_index;
  logic [DW-1:0]   out_min;
  logic [DW-1:0]   out_max;
  logic            out_last;
  logic            busy;
  logic            frame_done;
  logic            overrun;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  interval_result_streamer #(.NUM_INTERVALS(N), .DATA_W(DW), .IDX_W(IW)) dut (
    .clk        (clk),
    .reset      (reset),
    .res_done   (res_done),
    .res_max    (res_max),
    .res_min    (res_min),
    .num_valid  (num_valid),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_index  (out_index),
    .out_min    (out_min),
    .out_max    (out_max),
    .out_last   (out_last),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  typedef struct {
    logic [IW-1:0] idx;
    logic [DW-1:0] mn;
    logic [DW-1:0] mx;
    logic          last;
  } beat_t;

  // Reference model: a frame is the list of beats still owed downstream,
  // followed by one frame_done cycle.
  beat_t exp_q[$];
  bit    m_fin  = 1'b0;
  bit    m_ovr  = 1'b0;
  bit    m_prev = 1'b1;
  bit    m_rst  = 1'b0;

  beat_t got[$];
  int    hs_count     = 0;
  int    fd_count     = 0;
  int    valid_cycles = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    bit    rise;
    int    n;
    beat_t b;
    if (reset) begin
      exp_q.delete();
      m_fin  = 1'b0;
      m_ovr  = 1'b0;
      m_prev = 1'b1;
      m_rst  = 1'b1;
    end else begin
      rise   = res_done && !m_prev;
      m_prev = res_done;
      m_rst  = 1'b0;
      if (m_fin) begin
        m_fin = 1'b0;
        if (rise) m_ovr = 1'b1;
      end else if (exp_q.size() != 0) begin
        if (rise) m_ovr = 1'b1;
        if (out_ready) begin
          b = exp_q.pop_front();
          if (b.last) m_fin = 1'b1;
        end
      end else if (rise) begin
        n = (int'(num_valid) > N) ? N : int'(num_valid);
        if (n == 0) m_fin = 1'b1;
        for (int i = 0; i < n; i++) begin
          b.idx  = IW'(i);
          b.mn   = res_min[i*DW +: DW];
          b.mx   = res_max[i*DW +: DW];
          b.last = (i == n - 1);
          exp_q.push_back(b);
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    bit streaming;
    streaming = (exp_q.size() != 0);
    check("out_valid",  out_valid,  streaming);
    check("busy",       busy,       streaming || m_fin);
    check("frame_done", frame_done, m_fin);
    check("overrun",    overrun,    m_ovr);
    if (streaming) begin
      check("out_index", out_index, exp_q[0].idx);
      check("out_min",   out_min,   exp_q[0].mn);
      check("out_max",   out_max,   exp_q[0].mx);
      check("out_last",  out_last,  exp_q[0].last);
    end else if (m_rst) begin
      check("rst_out_index", out_index, 0);
      check("rst_out_min",   out_min,   0);
      check("rst_out_max",   out_max,   0);
      check("rst_out_last",  out_last,  0);
    end
    if (out_valid && out_ready) begin
      got.push_back('{out_index, out_min, out_max, out_last});
      hs_count++;
    end
    if (frame_done) fd_count++;
    if (out_valid)  valid_cycles++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < N; i++) begin
      res_min[i*DW +: DW] = DW'(10 * i);
      res_max[i*DW +: DW] = DW'(10 * i + 9);
    end
  endtask

  task automatic fill_const(input int mn, input int mx);
    for (int i = 0; i < N; i++) begin
      res_min[i*DW +: DW] = DW'(mn);
      res_max[i*DW +: DW] = DW'(mx);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) begin
      res_min[i*DW +: DW] = DW'($urandom);
      res_max[i*DW +: DW] = DW'($urandom);
    end
  endtask

  task automatic start_frame();
    got.delete();
    res_done = 1'b0;
    tick();
    res_done = 1'b1;
  endtask

  // mode 0: ready held high; mode 1: ready pattern 1,0,0; mode 2: random ready,
  // stray done toggles and input churn.
  task automatic wait_frame(input int mode, output int cycles);
    int fd0;
    bit done;
    fd0    = fd_count;
    done   = 1'b0;
    cycles = 0;
    for (int c = 0; c < 400; c++) begin
      case (mode)
        1:       out_ready = (c % 3 == 0);
        2: begin
          out_ready = 1'($urandom_range(0, 1));
          if (c >= 2 && $urandom_range(0, 19) == 0) res_done = ~res_done;
          if ($urandom_range(0, 3) == 0) fill_random();
        end
        default: out_ready = 1'b1;
      endcase
      tick();
      if (fd_count != fd0) begin
        done   = 1'b1;
        cycles = c + 1;
        break;
      end
    end
    if (!done) check("frame_timeout", 0, 1);
  endtask

  task automatic wait_beat(input int k);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (out_valid && int'(out_index) == k) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) check("beat_timeout", 0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int v0;
    reset     = 1'b1;
    res_done  = 1'b1;
    out_ready = 1'b1;
    num_valid = IW'(10);
    fill_ramp();
    repeat (3) tick();
    reset = 1'b0;
    repeat (3) tick();
    check("done_high_through_reset_busy", busy, 0);

    // Ramp frame, ready held high.
    start_frame();
    wait_frame(0, cyc);
    check("ramp_beats", got.size(), 10);
    check("ramp_latency", cyc, 12);
    if (got.size() == 10) begin
      check("ramp_b0_min",  got[0].mn, 0);
      check("ramp_b0_max",  got[0].mx, 9);
      check("ramp_b9_min",  got[9].mn, 90);
      check("ramp_b9_max",  got[9].mx, 99);
      check("ramp_b9_last", got[9].last, 1);
      check("ramp_b8_last", got[8].last, 0);
    end

    // Backpressure: every index handed over exactly once, in order.
    start_frame();
    wait_frame(1, cyc);
    check("bp_beats", got.size(), 10);
    for (int i = 0; i < got.size(); i++) check("bp_index", got[i].idx, i);

    // Signed constant slots with num_valid clamped.
    fill_const(-100, 100);
    num_valid = IW'(15);
    start_frame();
    wait_frame(0, cyc);
    check("signed_beats", got.size(), 10);
    if (got.size() == 10) begin
      check("signed_min_bits", got[0].mn, 32'hFFFF_FF9C);
      check("signed_max",      got[0].mx, 100);
      check("signed_last_idx", got[9].idx, 9);
      check("signed_last",     got[9].last, 1);
    end

    // Empty frame.
    num_valid = '0;
    v0 = valid_cycles;
    start_frame();
    wait_frame(0, cyc);
    check("empty_beats", got.size(), 0);
    check("empty_valid_cycles", valid_cycles - v0, 0);
    check("empty_latency", cyc, 2);

    // Overrun during beat 3 with changed inputs.
    fill_ramp();
    num_valid = IW'(10);
    out_ready = 1'b1;
    start_frame();
    wait_beat(3);
    out_ready = 1'b0;
    res_done  = 1'b0;
    tick();
    fill_const(777, 777);
    res_done = 1'b1;
    tick();
    wait_frame(0, cyc);
    check("ovr_set", overrun, 1);
    check("ovr_beats", got.size(), 10);
    if (got.size() == 10) begin
      check("ovr_b3_min", got[3].mn, 30);
      check("ovr_b9_max", got[9].mx, 99);
    end
    res_done = 1'b0;
    repeat (4) tick();
    check("ovr_no_second_frame", busy, 0);
    check("ovr_sticky", overrun, 1);

    // Reset mid-stream with done held high across it.
    fill_ramp();
    start_frame();
    wait_beat(5);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_valid", out_valid, 0);
    start_frame();
    wait_frame(0, cyc);
    check("rst_refill_beats", got.size(), 10);
    if (got.size() == 10) begin
      check("rst_refill_b0_idx", got[0].idx, 0);
      check("rst_refill_b9_max", got[9].mx, 99);
    end

    // Randomized frames.
    for (int f = 0; f < 40; f++) begin
      fill_random();
      num_valid = IW'($urandom_range(0, 14));
      start_frame();
      wait_frame(2, cyc);
    end
    res_done = 1'b0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
